// File: rtl/ssd_arb_pkg.sv
// Shared definitions for the seven-segment display arbiter: FSM encoding,
// dwell-time conversion and index wrap helper.
package ssd_arb_pkg;

  // Largest number of requesters the arbiter is built for.
  localparam int MAX_REQ = 8;

  // FSM encoding, kept as plain constants so the state value is easy to probe.
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SHOW = 1'b1;

  typedef enum logic [0:0] {
    IDLE = ST_IDLE,
    SHOW = ST_SHOW
  } state_e;

  // Number of clock cycles in a dwell period of 'us' microseconds.
  function automatic int unsigned dwell_cycles(input int unsigned clk_hz,
                                               input int unsigned us);
    return clk_hz / 1_000_000 * us;
  endfunction

  // idx+1 wrapped into 0..n-1.
  function automatic int unsigned wrap_inc(input int unsigned idx,
                                           input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/ssd_display_arbiter_rr_pick.sv
// Combinational round-robin picker: returns the first set bit of mask_i at or
// after start_i, wrapping past N-1 back to 0.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  mask_i,
  input  logic [IW-1:0] start_i,
  output logic [N-1:0]  onehot_o,
  output logic [IW-1:0] idx_o,
  output logic          valid_o
);

  logic [N-1:0] rot;
  logic [IW:0]  pos;

  // Rotate the mask so bit 0 is the start position, then take the lowest set
  // bit; the downward loop lets the smallest offset win.
  always_comb begin
    rot      = N'({mask_i, mask_i} >> start_i);
    onehot_o = '0;
    idx_o    = '0;
    valid_o  = 1'b0;
    pos      = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) begin
        pos = {1'b0, start_i} + (IW + 1)'(k);
        if (pos >= (IW + 1)'(N)) begin
          pos = pos - (IW + 1)'(N);
        end
        idx_o   = pos[IW-1:0];
        valid_o = 1'b1;
      end
    end
    if (valid_o) begin
      onehot_o[idx_o] = 1'b1;
    end
  end

endmodule

// File: rtl/ssd_display_arbiter.sv
// Round-robin time-sharing of the 8-digit seven-segment display among NUM_REQ
// requesters, each keeping the display for a fixed dwell time while others
// wait. All outputs are registered and feed seven_segment8 directly.
//
// Optional feature: define SSD_ARB_PRIORITY_EN to make requester 0 urgent; a
// rising req[0] preempts any other owner on the next cycle.
module ssd_display_arbiter
  import ssd_arb_pkg::*;
#(
  parameter int CLK_FREQUENCY = 100_000_000,
  parameter int DWELL_US      = 1_000_000,
  parameter int NUM_REQ       = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*32-1:0]      req_data,
  input  logic [NUM_REQ*8-1:0]       req_dp,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] owner,
  output logic [31:0]                data_out,
  output logic [7:0]                 dp_out,
  output logic                       blank_out
);

  localparam int DWELL_CYCLES = int'(dwell_cycles(CLK_FREQUENCY, DWELL_US));
  localparam int IW           = $clog2(NUM_REQ);
  localparam int CW           = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(DWELL_CYCLES - 1);

  if (DWELL_CYCLES < 2) begin : g_bad_dwell
    $fatal(1, "ssd_display_arbiter: dwell must be at least 2 clock cycles");
  end

  if (NUM_REQ < 2 || NUM_REQ > MAX_REQ) begin : g_bad_num_req
    $fatal(1, "ssd_display_arbiter: NUM_REQ must be within 2..8");
  end

  // Per-requester views of the packed data buses.
  logic [31:0] word [NUM_REQ];
  logic [7:0]  dpw  [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_split
    assign word[g] = req_data[32*g +: 32];
    assign dpw[g]  = req_dp[8*g +: 8];
  end

  state_e              state_q, state_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [IW-1:0]       owner_q, owner_d;
  logic [31:0]         data_q, data_d;
  logic [7:0]          dp_q, dp_d;
  logic                blank_q, blank_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [IW-1:0]       ptr_q, ptr_d;

  logic [NUM_REQ-1:0]  pick_mask;
  logic [IW-1:0]       pick_start;
  logic [NUM_REQ-1:0]  pick_oh;
  logic [IW-1:0]       pick_idx;
  logic                pick_valid;
  logic [IW-1:0]       owner_inc;
  logic                owner_req;
  logic                preempt;
  logic                switch_en;
  logic [IW-1:0]       switch_idx;

  assign owner_inc = IW'(wrap_inc(32'(owner_q), NUM_REQ));
  assign owner_req = |(req & grant_q);

`ifdef SSD_ARB_PRIORITY_EN
  logic req0_q;

  // Remember last req[0] so only a rising edge counts as an urgent request.
  always_ff @(posedge clk) begin
    if (!rst) begin
      req0_q <= 1'b0;
    end else begin
      req0_q <= req[0];
    end
  end

  assign preempt = (state_q == SHOW) && req[0] && !req0_q && (owner_q != '0);
`else
  assign preempt = 1'b0;
`endif

  // While idle, search from the RR pointer; while showing, search from the
  // owner's successor with the owner masked out (a dropped owner has no bit
  // set anyway, so the same mask serves both the drop and expiry cases).
  always_comb begin
    pick_mask  = req;
    pick_start = ptr_q;
    if (state_q == SHOW) begin
      pick_mask  = req & ~grant_q;
      pick_start = owner_inc;
    end
  end

  rr_pick #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_pick (
    .mask_i   (pick_mask),
    .start_i  (pick_start),
    .onehot_o (pick_oh),
    .idx_o    (pick_idx),
    .valid_o  (pick_valid)
  );

  // Ownership decisions: grant, dwell countdown, drop and expiry handling,
  // plus the live data/dp capture for whoever owns the display next cycle.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    owner_d    = owner_q;
    blank_d    = blank_q;
    cnt_d      = cnt_q;
    ptr_d      = ptr_q;
    switch_en  = 1'b0;
    switch_idx = pick_idx;

    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          switch_en = 1'b1;
        end
      end
      SHOW: begin
        if (preempt) begin
          switch_en  = 1'b1;
          switch_idx = '0;
        end else if (!owner_req) begin
          if (pick_valid) begin
            switch_en = 1'b1;
          end else begin
            state_d = IDLE;
            grant_d = '0;
            blank_d = 1'b1;
            cnt_d   = '0;
          end
        end else if (cnt_q == '0) begin
          // Nobody else waiting: keep the owner and start a fresh dwell
          // without ever dropping grant.
          if (pick_valid) begin
            switch_en = 1'b1;
          end else begin
            cnt_d = RELOAD;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: ;
    endcase

    if (switch_en) begin
      state_d = SHOW;
      grant_d = preempt ? NUM_REQ'(1) : pick_oh;
      owner_d = switch_idx;
      blank_d = 1'b0;
      cnt_d   = RELOAD;
      ptr_d   = IW'(wrap_inc(32'(switch_idx), NUM_REQ));
    end

    // Idle keeps the last displayed value behind the blanking.
    data_d = data_q;
    dp_d   = dp_q;
    if (state_d == SHOW) begin
      data_d = word[owner_d];
      dp_d   = dpw[owner_d];
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      owner_q <= '0;
      data_q  <= '0;
      dp_q    <= '0;
      blank_q <= 1'b1;
      cnt_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      data_q  <= data_d;
      dp_q    <= dp_d;
      blank_q <= blank_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
    end
  end

  assign grant     = grant_q;
  assign owner     = owner_q;
  assign data_out  = data_q;
  assign dp_out    = dp_q;
  assign blank_out = blank_q;

endmodule

// File: tb/tb_ssd_display_arbiter.sv
// Self-checking bench for ssd_display_arbiter with a 10-cycle dwell. Directed
// scenarios followed by randomized traffic, all checked against a behavioural
// ownership model. Honours SSD_ARB_PRIORITY_EN when defined.
module tb_ssd_display_arbiter;

  localparam int N     = 4;
  localparam int DWELL = 10;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]    req      = '0;
  logic [N*32-1:0] req_data = '0;
  logic [N*8-1:0]  req_dp   = '0;
  logic [N-1:0]    grant;
  logic [1:0]      owner;
  logic [31:0]     data_out;
  logic [7:0]      dp_out;
  logic            blank_out;

  ssd_display_arbiter #(
    .CLK_FREQUENCY (1_000_000),
    .DWELL_US      (10),
    .NUM_REQ       (N)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_data  (req_data),
    .req_dp    (req_dp),
    .grant     (grant),
    .owner     (owner),
    .data_out  (data_out),
    .dp_out    (dp_out),
    .blank_out (blank_out)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [N-1:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // m_owner = -1 when nobody holds the display; m_shown counts the cycles the
  // current owner has been on the display, 1 on the first granted cycle.
  int          m_owner = -1;
  int          m_last  = 0;
  int          m_shown = 0;
  int          m_ptr   = 0;
  bit          m_prev0 = 0;
  logic [31:0] m_data  = '0;
  logic [7:0]  m_dp    = '0;

  function automatic int first_from(input logic [N-1:0] r, input int start, input int excl);
    for (int k = 0; k < N; k++) begin
      int i;
      i = (start + k) % N;
      if (i != excl && r[i]) return i;
    end
    return -1;
  endfunction

  task automatic give(input int w);
    m_owner = w;
    m_last  = w;
    m_shown = 1;
    m_ptr   = (w + 1) % N;
  endtask

  task automatic model_step();
    int w;
    bit urgent;
    if (!rst) begin
      m_owner = -1; m_last = 0; m_shown = 0; m_ptr = 0; m_prev0 = 0;
      m_data  = '0; m_dp = '0;
      return;
    end
    urgent = 0;
`ifdef SSD_ARB_PRIORITY_EN
    urgent = (m_owner > 0) && req[0] && !m_prev0;
`endif
    if (m_owner < 0) begin
      w = first_from(req, m_ptr, -1);
      if (w >= 0) give(w);
    end else if (urgent) begin
      give(0);
    end else if (!req[m_owner]) begin
      w = first_from(req, (m_owner + 1) % N, -1);
      if (w >= 0) give(w);
      else m_owner = -1;
    end else if (m_shown == DWELL) begin
      w = first_from(req, (m_owner + 1) % N, m_owner);
      if (w >= 0) give(w);
      else m_shown = 1;
    end else begin
      m_shown++;
    end
    if (m_owner >= 0) begin
      m_data = req_data[32*m_owner +: 32];
      m_dp   = req_dp[8*m_owner +: 8];
    end
    m_prev0 = req[0];
  endtask

  task automatic check_model();
    check_eq("grant", 64'(grant), (m_owner < 0) ? 64'd0 : (64'd1 << m_owner));
    check_eq("owner", 64'(owner), 64'(m_last));
    check_eq("blank", 64'(blank_out), 64'(m_owner < 0));
    check_eq("data", 64'(data_out), 64'(m_data));
    check_eq("dp", 64'(dp_out), 64'(m_dp));
    check_eq("onehot0", 64'($onehot0(grant)), 64'd1);
  endtask

  // ---------------- driver tasks ----------------
  // Inputs are changed after the falling edge; the model steps on the rising
  // edge with the same inputs the DUT samples; outputs are checked on the
  // next falling edge.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_model();
  endtask

  task automatic rand_data();
    for (int i = 0; i < N; i++) begin
      req_data[32*i +: 32] = $urandom();
      req_dp[8*i +: 8]     = 8'($urandom_range(0, 255));
    end
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b0;
    repeat (cycles) tick();
    rst = 1'b1;
  endtask

  logic [31:0] hold_val;
  logic [N-1:0] owner_seq [5];

  initial begin
    // 1: reset held with every requester asking
    rand_data();
    req = 4'hF;
    rst = 1'b0;
    repeat (5) begin
      tick();
      check_eq("t1_grant", 64'(grant), 64'd0);
      check_eq("t1_blank", 64'(blank_out), 64'd1);
      check_eq("t1_data", 64'(data_out), 64'd0);
      check_eq("t1_dp", 64'(dp_out), 64'd0);
    end

    // 2: single requester keeps the display indefinitely
    rst = 1'b1;
    req = 4'b0100;
    req_data[64 +: 32] = 32'hdeadbeef;
    req_dp[16 +: 8]    = 8'hf0;
    tick();
    check_eq("t2_grant", 64'(grant), 64'h4);
    check_eq("t2_data", 64'(data_out), 64'hdeadbeef);
    check_eq("t2_dp", 64'(dp_out), 64'hf0);
    repeat (49) begin
      tick();
      check_eq("t2_hold", 64'(grant), 64'h4);
    end

    // 3: three steady requesters rotate with exactly DWELL cycles each
    do_reset(2);
    req = 4'b1011;
    owner_seq = '{4'b0001, 4'b0010, 4'b1000, 4'b0001, 4'b0010};
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < DWELL; c++) exp_q.push_back(owner_seq[r]);
    while (exp_q.size() > 0) begin
      rand_data();
      tick();
      check_eq("t3_rr", 64'(grant), 64'(exp_q.pop_front()));
    end

    // 4: owner drops mid-dwell, then everybody drops
    do_reset(2);
    req = 4'b1011;
    repeat (13) tick();
    check_eq("t4_owner1", 64'(grant), 64'h2);
    req = 4'b1001;
    tick();
    check_eq("t4_switch", 64'(grant), 64'h8);
    hold_val = req_data[96 +: 32];
    req = 4'b0000;
    rand_data();
    tick();
    check_eq("t4_idle_grant", 64'(grant), 64'd0);
    check_eq("t4_idle_blank", 64'(blank_out), 64'd1);
    check_eq("t4_idle_data", 64'(data_out), 64'(hold_val));

    // 5: reset in the middle of a dwell
    req = 4'b0110;
    repeat (6) tick();
    check_eq("t5_show", 64'(grant), 64'h2);
    rst = 1'b0;
    tick();
    check_eq("t5_rst_grant", 64'(grant), 64'd0);
    check_eq("t5_rst_owner", 64'(owner), 64'd0);
    check_eq("t5_rst_blank", 64'(blank_out), 64'd1);
    check_eq("t5_rst_data", 64'(data_out), 64'd0);
    rst = 1'b1;
    tick();
    check_eq("t5_first", 64'(grant), 64'h2);

    // 6: requester 0 arrives while requester 2 is showing
    do_reset(2);
    req = 4'b0100;
    repeat (3) tick();
    req = 4'b0101;
    tick();
`ifdef SSD_ARB_PRIORITY_EN
    check_eq("t6_preempt", 64'(grant), 64'h1);
`else
    check_eq("t6_wait", 64'(grant), 64'h4);
`endif
    repeat (6) tick();
`ifdef SSD_ARB_PRIORITY_EN
    check_eq("t6_keep0", 64'(grant), 64'h1);
`else
    check_eq("t6_last2", 64'(grant), 64'h4);
`endif
    tick();
    check_eq("t6_expiry", 64'(grant), 64'h1);

    // 7: randomized traffic with sticky requests and occasional resets
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rand_data();
      if ($urandom_range(0, 5) == 0) req = 4'($urandom_range(0, 15));
      rst = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
